// File: rtl/ui_input_ctrl.sv
// Board UI input controller: synchronised, debounced KEYS/SWITCHES latched into polled DATA/CTRL registers.
// Optional interrupt support is compiled in when UI_IRQ_EN is defined.

module ui_input_ctrl_deb #(
  parameter int unsigned W          = 4,
  parameter int unsigned DEB_CYCLES = 15,
  parameter bit          INVERT     = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] sample_o,
  output logic         evt_o
);
  localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [W-1:0]  sync1_q, sync2_q;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sample;

  assign sample   = INVERT ? ~sync2_q : sync2_q;
  assign sample_o = sample;

  // The cycle the count would reach DEB_CYCLES-1 is the accepting cycle, so the
  // counter never holds that value and the new level lands 2+DEB_CYCLES edges after the raw edge.
  always_comb begin
    prev_d   = sample;
    stable_d = stable_q;
    cnt_d    = '0;
    evt_o    = 1'b0;
    if (sample != prev_q || sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 2)) begin
      stable_d = sample;
      evt_o    = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module ui_input_ctrl #(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned NKEYS      = 4,
  parameter int unsigned NSW        = 10,
  parameter int unsigned DEB_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [1:0]       regSel,
  input  logic [DBITS-1:0] in,
  input  logic [NKEYS-1:0] KEYS,
  input  logic [NSW-1:0]   SWITCHES,
  output logic [DBITS-1:0] out,
  output logic             irq
);
  typedef enum logic [1:0] {
    SEL_KDATA = 2'd0,
    SEL_KCTRL = 2'd1,
    SEL_SDATA = 2'd2,
    SEL_SCTRL = 2'd3
  } reg_sel_e;

  reg_sel_e         sel;
  logic [NKEYS-1:0] k_sample;
  logic [NSW-1:0]   s_sample;
  logic             k_evt, s_evt;
  logic [NKEYS-1:0] kdata_q, kdata_d;
  logic [NSW-1:0]   sdata_q, sdata_d;
  logic             kready_q, kready_d, kovr_q, kovr_d;
  logic             sready_q, sready_d, sovr_q, sovr_d;
  logic             k_ie, s_ie;
  logic             rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
  logic             unused_in;

  assign sel       = reg_sel_e'(regSel);
  assign rd_kdata  = rdEn  && (sel == SEL_KDATA);
  assign rd_sdata  = rdEn  && (sel == SEL_SDATA);
  assign wr_kctrl  = wrtEn && (sel == SEL_KCTRL);
  assign wr_sctrl  = wrtEn && (sel == SEL_SCTRL);
  assign unused_in = ^in;

  ui_input_ctrl_deb #(.W(NKEYS), .DEB_CYCLES(DEB_CYCLES), .INVERT(1'b1)) u_key_deb (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (KEYS),
    .sample_o (k_sample),
    .evt_o    (k_evt)
  );

  ui_input_ctrl_deb #(.W(NSW), .DEB_CYCLES(DEB_CYCLES), .INVERT(1'b0)) u_sw_deb (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (SWITCHES),
    .sample_o (s_sample),
    .evt_o    (s_evt)
  );

  // Event is applied last so it wins over a same-cycle DATA read or OVERRUN clear;
  // a coincident DATA read consumes the old value, so no overrun is recorded then.
  always_comb begin
    kdata_d  = kdata_q;
    kready_d = kready_q;
    kovr_d   = kovr_q;
    sdata_d  = sdata_q;
    sready_d = sready_q;
    sovr_d   = sovr_q;
    if (rd_kdata) kready_d = 1'b0;
    if (rd_sdata) sready_d = 1'b0;
    if (wr_kctrl && !in[2]) kovr_d = 1'b0;
    if (wr_sctrl && !in[2]) sovr_d = 1'b0;
    if (k_evt) begin
      kdata_d  = k_sample;
      kready_d = 1'b1;
      if (kready_q && !rd_kdata) kovr_d = 1'b1;
    end
    if (s_evt) begin
      sdata_d  = s_sample;
      sready_d = 1'b1;
      if (sready_q && !rd_sdata) sovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kdata_q  <= '0;
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      sdata_q  <= '0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
    end else begin
      kdata_q  <= kdata_d;
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      sdata_q  <= sdata_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
    end
  end

`ifdef UI_IRQ_EN
  logic kie_q, kie_d, sie_q, sie_d, irq_q, irq_d;

  always_comb begin
    kie_d = wr_kctrl ? in[8] : kie_q;
    sie_d = wr_sctrl ? in[8] : sie_q;
    irq_d = (kready_q & kie_q) | (sready_q & sie_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kie_q <= 1'b0;
      sie_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      kie_q <= kie_d;
      sie_q <= sie_d;
      irq_q <= irq_d;
    end
  end

  assign k_ie = kie_q;
  assign s_ie = sie_q;
  assign irq  = irq_q;
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    out = '0;
    if (rdEn) begin
      unique case (sel)
        SEL_KDATA: out = DBITS'(kdata_q);
        SEL_KCTRL: begin
          out[0] = kready_q;
          out[2] = kovr_q;
          out[8] = k_ie;
        end
        SEL_SDATA: out = DBITS'(sdata_q);
        SEL_SCTRL: begin
          out[0] = sready_q;
          out[2] = sovr_q;
          out[8] = s_ie;
        end
        default: out = '0;
      endcase
    end
  end
endmodule
